// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: grant encoding,
// the hard-wired zero register and default widths.
package reg_file_wb_pkg;
    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;
    localparam int CW_DEFAULT = 16;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register. Ties go to the
// requester that was not granted last; hold blocks all grants.
module rr_arbiter2
    import reg_file_wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last_grant
);

    always_comb begin
        gnt = 2'b00;
        if (!hold) begin
            if (req[0] && (!req[1] || last_grant == GRANT_B)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // Reset to B so that A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= GRANT_B;
        end else if (gnt[0]) begin
            last_grant <= GRANT_A;
        end else if (gnt[1]) begin
            last_grant <= GRANT_B;
        end
    end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Arbitrates the register file write port between ALU (A) and load (B) writeback.
// Optional macro WB_BYPASS_EN adds forwarding compare outputs for two read ports.
module reg_file_wb_arbiter
    import reg_file_wb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_data_i,
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_data_i,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0] rd1_addr_i,
    input  logic [AW-1:0] rd2_addr_i,
    output logic          fwd1_hit_o,
    output logic          fwd2_hit_o,
    output logic [DW-1:0] fwd1_data_o,
    output logic [DW-1:0] fwd2_data_o,
`endif
    output logic          Reg_Write_o,
    output logic [AW-1:0] Write_Register_o,
    output logic [DW-1:0] Write_Data_o,
    output logic          last_grant_o,
    output logic [CW-1:0] conflict_cnt_o
);

    logic       hold_eff;
    logic [1:0] gnt;
    logic       conflict;

    // No handshakes while reset is asserted, even though ready is combinational.
    assign hold_eff = hold_i | ~reset;
    assign conflict = ~hold_eff & a_valid_i & b_valid_i;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold_eff),
        .req        ({b_valid_i, a_valid_i}),
        .gnt        (gnt),
        .last_grant (last_grant_o)
    );

    assign a_ready_o = gnt[0];
    assign b_ready_o = gnt[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_o <= '0;
        end else if (conflict && conflict_cnt_o != '1) begin
            conflict_cnt_o <= conflict_cnt_o + CW'(1);
        end
    end

    // Writes to $zero complete the handshake but never assert the write enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else begin
            Reg_Write_o <= 1'b0;
            if (gnt[0]) begin
                Write_Register_o <= a_addr_i;
                Write_Data_o     <= a_data_i;
                Reg_Write_o      <= (a_addr_i != AW'(ZERO_REG));
            end else if (gnt[1]) begin
                Write_Register_o <= b_addr_i;
                Write_Data_o     <= b_data_i;
                Reg_Write_o      <= (b_addr_i != AW'(ZERO_REG));
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Covers the cycle where the write is registered but not yet in the file.
    assign fwd1_hit_o  = Reg_Write_o && (rd1_addr_i == Write_Register_o) &&
                         (rd1_addr_i != AW'(ZERO_REG));
    assign fwd2_hit_o  = Reg_Write_o && (rd2_addr_i == Write_Register_o) &&
                         (rd2_addr_i != AW'(ZERO_REG));
    assign fwd1_data_o = Write_Data_o;
    assign fwd2_data_o = Write_Data_o;
`endif

endmodule
